// File: rtl/timer_irq_source_pkg.sv
// Shared register map, TCON bit positions and state encodings for the interval timer.
package timer_defs;

    localparam int unsigned TIMER_DATA_W   = 32;
    localparam int unsigned TIMER_TH_OFS   = 0;
    localparam int unsigned TIMER_TL_OFS   = 4;
    localparam int unsigned TIMER_TCON_OFS = 8;
    localparam int unsigned TIMER_PSC_OFS  = 12;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_ST = 2;
    localparam int unsigned TCON_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } timer_state_e;

    // Word select inside the 16-byte register window (Addr[3:2]).
    typedef enum logic [1:0] {
        REG_TH   = 2'(TIMER_TH_OFS >> 2),
        REG_TL   = 2'(TIMER_TL_OFS >> 2),
        REG_TCON = 2'(TIMER_TCON_OFS >> 2),
        REG_PSC  = 2'(TIMER_PSC_OFS >> 2)
    } timer_reg_e;

    // Field order matches the bit positions: st = bit 2, ie = bit 1, en = bit 0.
    typedef struct packed {
        logic st;
        logic ie;
        logic en;
    } tcon_t;

endpackage

// File: rtl/timer_irq_source_prescaler.sv
// Tick divider: fires every (psc_i + 1) enabled cycles; holds while disabled, clears on PSC write.
module timer_prescaler #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] psc_i,
    output logic         tick_c_o
);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    assign tick_c_o = en_i & (div_q == psc_i);

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (tick_c_o) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = div_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer driving the level irq line; TH/TL/TCON (+PSC) at BASE_ADDR.
// Optional tick prescaler enabled by defining TIMER_PRESCALE_EN.
module timer_irq_source
    import timer_defs::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        irq
);

    logic [TIMER_DATA_W-1:0] th_q, th_d;
    logic [TIMER_DATA_W-1:0] tl_q, tl_d;
    tcon_t                   tcon_q, tcon_d;
    logic                    irq_q, irq_d;
    timer_state_e            state_q, state_d;

    logic                    blk_hit_c;
    timer_reg_e              sel_c;
    logic                    wr_th_c, wr_tl_c, wr_tcon_c;
    logic                    tick_c;
    logic                    wrap_c;
    logic [PRESCALE_W-1:0]   psc_rd_c;
    logic                    unused_addr_lsb_c;

    // BASE_ADDR is assumed 16-byte aligned; byte-lane bits are don't-care.
    assign blk_hit_c         = (Addr[31:4] == BASE_ADDR[31:4]);
    assign sel_c             = timer_reg_e'(Addr[3:2]);
    assign unused_addr_lsb_c = ^Addr[1:0];

    assign wr_th_c   = MemWr & blk_hit_c & (sel_c == REG_TH);
    assign wr_tl_c   = MemWr & blk_hit_c & (sel_c == REG_TL);
    assign wr_tcon_c = MemWr & blk_hit_c & (sel_c == REG_TCON);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_q;
    logic                  wr_psc_c;

    assign wr_psc_c = MemWr & blk_hit_c & (sel_c == REG_PSC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
        end else if (wr_psc_c) begin
            psc_q <= WriteData[PRESCALE_W-1:0];
        end
    end

    timer_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk_i    (clk),
        .rst_i    (reset),
        .en_i     (tcon_q.en),
        .clr_i    (wr_psc_c),
        .psc_i    (psc_q),
        .tick_c_o (tick_c)
    );

    assign psc_rd_c = psc_q;
`else
    assign tick_c   = 1'b1;
    assign psc_rd_c = '0;
`endif

    assign wrap_c = tick_c & tcon_q.en & (tl_q == '1);

    // Register next-state; bus writes override the count, but a wrap always sets ST.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        irq_d  = tcon_q.ie & tcon_q.st;

        if (tick_c && tcon_q.en) begin
            tl_d = wrap_c ? th_q : tl_q + 32'd1;
        end
        if (wr_tl_c) begin
            tl_d = WriteData;
        end
        if (wr_th_c) begin
            th_d = WriteData;
        end
        if (wr_tcon_c) begin
            tcon_d = tcon_t'(WriteData[TCON_W-1:0]);
        end
        if (wrap_c) begin
            tcon_d.st = 1'b1;
        end
    end

    // Coverage-only state tracking derived from the next EN/IE/ST values.
    always_comb begin
        state_d = state_q;
        if (!tcon_d.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (wrap_c && tcon_d.ie) state_d = PEND;
                PEND:    if (!tcon_d.st) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
            irq_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            irq_q   <= irq_d;
            state_q <= state_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        ReadData = '0;
        if (MemRd && blk_hit_c) begin
            case (sel_c)
                REG_TH:   ReadData = th_q;
                REG_TL:   ReadData = tl_q;
                REG_TCON: ReadData = 32'(tcon_q);
                REG_PSC:  ReadData = 32'(psc_rd_c);
                default:  ReadData = '0;
            endcase
        end
    end

    a_pend_implies_en_st: assert property (@(posedge clk) disable iff (reset)
        (state_q == PEND) |-> (tcon_q.en && tcon_q.st));
    a_idle_iff_disabled: assert property (@(posedge clk) disable iff (reset)
        ((state_q == IDLE) == !tcon_q.en));

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: register table plus reset/wrap/irq/prescale sequences.
module tb_timer_irq_source;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef TIMER_PRESCALE_EN
    localparam bit PSC_ON = 1'b1;
`else
    localparam bit PSC_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    timer_irq_source dut (
        .clk       (clk),
        .reset     (reset),
        .MemRd     (MemRd),
        .MemWr     (MemWr),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWr     = 1'b1;
        Addr      = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWr     = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp,
                          input bit rd);
        MemRd = rd;
        Addr  = a;
        exp_q.push_back(exp);
        nm_q.push_back(name);
        #1;
        chk(nm_q.pop_front(), ReadData, exp_q.pop_front());
        MemRd = 1'b0;
    endtask

    task automatic irq_chk(input string name, input logic exp);
        chk(name, 32'(irq), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;

        reset = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WriteData = '0;
        step(2);
        reset = 1'b0;

        irq_chk("reset_irq", 1'b0);
        rd_chk("reset_tcon", BASE + 8, 32'h0, 1'b1);

        // Asynchronous reset mid-run with irq asserted.
        wr(BASE + 4, 32'd5);
        wr(BASE + 8, 32'd7);
        step(1);
        irq_chk("pre_reset_irq", 1'b1);
        rd_chk("pre_reset_tl", BASE + 4, 32'd6, 1'b1);
        reset = 1'b1;
        #1;
        irq_chk("async_reset_irq", 1'b0);
        rd_chk("async_reset_tl", BASE + 4, 32'h0, 1'b1);
        rd_chk("async_reset_tcon", BASE + 8, 32'h0, 1'b1);
        reset = 1'b0;
        step(1);

        // Register map table (timer stopped).
        vecs.push_back('{1'b1, 1'b0, BASE + 0,  32'h1234_5678, 32'h0,         "w_th"});
        vecs.push_back('{1'b1, 1'b0, BASE + 4,  32'hA5A5_0001, 32'h0,         "w_tl"});
        vecs.push_back('{1'b1, 1'b0, BASE + 8,  32'hFFFF_FFF2, 32'h0,         "w_tcon"});
        vecs.push_back('{1'b0, 1'b1, BASE + 0,  32'h0,         32'h1234_5678, "r_th"});
        vecs.push_back('{1'b0, 1'b1, BASE + 4,  32'h0,         32'hA5A5_0001, "r_tl"});
        vecs.push_back('{1'b0, 1'b1, BASE + 8,  32'h0,         32'h0000_0002, "r_tcon"});
        vecs.push_back('{1'b0, 1'b1, BASE + 1,  32'h0,         32'h1234_5678, "r_th_lsb"});
        vecs.push_back('{1'b0, 1'b1, BASE + 11, 32'h0,         32'h0000_0002, "r_tcon_lsb"});
        vecs.push_back('{1'b0, 1'b1, BASE + 16, 32'h0,         32'h0,         "r_base16"});
        vecs.push_back('{1'b0, 1'b1, BASE + 12, 32'h0,         32'h0,         "r_psc_rst"});
        vecs.push_back('{1'b0, 1'b1, 32'h4,     32'h0,         32'h0,         "r_miss"});
        vecs.push_back('{1'b1, 1'b0, 32'h0,     32'hFFFF_FFFF, 32'h0,         "w_miss"});
        vecs.push_back('{1'b0, 1'b1, BASE + 0,  32'h0,         32'h1234_5678, "r_th_after_miss"});
        vecs.push_back('{1'b1, 1'b0, BASE + 16, 32'h0000_0001, 32'h0,         "w_base16"});
        vecs.push_back('{1'b0, 1'b1, BASE + 8,  32'h0,         32'h0000_0002, "r_tcon_after16"});
        vecs.push_back('{1'b0, 1'b0, BASE + 0,  32'h0,         32'h0,         "r_memrd0"});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            else rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp, vecs[i].rd);
        end

        // Wrap from FFFF_FFFF to TH, ST set at wrap, irq one cycle later.
        wr(BASE + 0, 32'hFFFF_FFFC);
        wr(BASE + 4, 32'hFFFF_FFFE);
        wr(BASE + 8, 32'd3);
        rd_chk("wrap_tl0", BASE + 4, 32'hFFFF_FFFE, 1'b1);
        step(1);
        rd_chk("wrap_tl1", BASE + 4, 32'hFFFF_FFFF, 1'b1);
        rd_chk("wrap_tcon_pre", BASE + 8, 32'd3, 1'b1);
        step(1);
        rd_chk("wrap_tl_reload", BASE + 4, 32'hFFFF_FFFC, 1'b1);
        rd_chk("wrap_st", BASE + 8, 32'd7, 1'b1);
        irq_chk("wrap_irq_lag", 1'b0);
        step(1);
        irq_chk("wrap_irq_rise", 1'b1);

        // Clearing ST drops irq; each later wrap gives a fresh edge 4 cycles apart.
        wr(BASE + 8, 32'd3);
        rd_chk("clr_tcon", BASE + 8, 32'd3, 1'b1);
        step(1);
        irq_chk("clr_irq_low", 1'b0);
        step(1);
        rd_chk("rewrap_st", BASE + 8, 32'd7, 1'b1);
        irq_chk("rewrap_irq_lag", 1'b0);
        step(1);
        irq_chk("rewrap_irq_rise", 1'b1);
        for (int k = 0; k < 3; k++) begin
            wr(BASE + 8, 32'd3);
            step(1);
            irq_chk("period_low", 1'b0);
            n = 1;
            while (irq !== 1'b1 && n < 12) begin
                step(1);
                n++;
            end
            chk("irq_period", 32'(n + 1), 32'd4);
        end

        // Simultaneous events on a wrap edge.
        wr(BASE + 8, 32'd0);
        wr(BASE + 4, 32'hFFFF_FFFE);
        wr(BASE + 8, 32'd3);
        step(2);
        rd_chk("sim_first_wrap", BASE + 8, 32'd7, 1'b1);
        step(1);
        irq_chk("sim_irq_high", 1'b1);
        step(2);
        rd_chk("sim_tl_ffff", BASE + 4, 32'hFFFF_FFFF, 1'b1);
        wr(BASE + 8, 32'd3);
        rd_chk("sim_clr_on_wrap_st", BASE + 8, 32'd7, 1'b1);
        rd_chk("sim_clr_on_wrap_tl", BASE + 4, 32'hFFFF_FFFC, 1'b1);
        irq_chk("sim_clr_irq", 1'b1);
        step(1);
        irq_chk("sim_clr_irq_hold", 1'b1);
        step(2);
        rd_chk("sim_tl_ffff2", BASE + 4, 32'hFFFF_FFFF, 1'b1);
        wr(BASE + 4, 32'd7);
        rd_chk("sim_wr_tl_on_wrap", BASE + 4, 32'd7, 1'b1);
        wr(BASE + 4, 32'hFFFF_FFFF);
        wr(BASE + 0, 32'h0000_0010);
        rd_chk("sim_wr_th_reload_old", BASE + 4, 32'hFFFF_FFFC, 1'b1);
        rd_chk("sim_wr_th_new", BASE + 0, 32'h0000_0010, 1'b1);

        // Prescaler: PSC = 3 divides ticks by 4, or is ignored without the feature.
        wr(BASE + 8, 32'd0);
        wr(BASE + 4, 32'd0);
        wr(BASE + 12, 32'd3);
        rd_chk("psc_read", BASE + 12, PSC_ON ? 32'd3 : 32'd0, 1'b1);
        wr(BASE + 8, 32'd1);
        rd_chk("psc_tl_start", BASE + 4, 32'd0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            rd_chk("psc_tl", BASE + 4, PSC_ON ? 32'(i / 4) : 32'(i), 1'b1);
        end
        wr(BASE + 8, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
